// File: rtl/bit_packer_pkg.sv
// bit_packer_pkg
//   Shared definitions for the serial-to-parallel bit packer:
//   - WIDTH_DEFAULT : default packed word width
//   - WORD_CNT_W    : width of the accepted-word counter
//   - state_t       : packer state (IDLE / FILL / STALL)
//   - cnt_width()   : bit count register width for a given word width
package bit_packer_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int WORD_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

    // Counter must hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bp_out_slot.sv
// bp_out_slot
//   One-entry output register holding a completed word until downstream
//   accepts it. A load in the same cycle as an accept replaces the word and
//   keeps the slot valid, so no word is lost or duplicated.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : a new completed word is written this edge
//   i_word     : the completed word
//   i_accept   : downstream ready
//   o_word     : held word
//   o_valid    : slot holds an unconsumed word
//   o_fire     : o_valid && i_accept (a word is consumed this edge)
module bp_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_accept,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_fire
);

    logic [WIDTH-1:0] r_word;
    logic             r_valid;

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_fire  = r_valid && i_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_valid <= 1'b1;
        end else if (o_fire) begin
            // Word consumed with nothing new arriving: keep data, drop valid.
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_packer.sv
// bit_packer
//   Packs a serial bit stream into WIDTH-bit words, first bit in the MSB.
//   Bits are consumed from an upstream holding stage through the drain
//   strobe; completed words are presented through a one-entry output slot.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bit_valid   : upstream holds a bit
//   bit_data    : the upstream bit
//   drain       : bit consumed this cycle (combinational)
//   abort       : discard the partially assembled word
//   out_word    : packed word
//   out_valid   : out_word holds an unconsumed word
//   out_ready   : downstream accepts out_word this cycle
//   word_cnt    : number of words accepted downstream (wrapping)
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    output logic                  drain,
    input  logic                  abort,
    output logic [WIDTH-1:0]      out_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Only the WIDTH-1 earlier bits need storing; the final bit goes
    // straight from bit_data into the output slot.
    logic [WIDTH-2:0]      r_sreg;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_CNT_W-1:0] r_word_cnt;

    logic [WIDTH-2:0]      w_sreg_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [WIDTH-1:0]      w_word_nxt;
    state_t                w_state;
    logic                  w_blocked;
    logic                  w_take;
    logic                  w_load;
    logic                  w_fire;
    logic                  w_out_valid;
    logic [WIDTH-1:0]      w_out_word;

    always_comb begin
        w_blocked   = w_out_valid && !out_ready;
        w_word_nxt  = {r_sreg, bit_data};
        w_sreg_nxt  = r_sreg;
        w_count_nxt = r_count;
        w_load      = 1'b0;

        // STALL: final bit is waiting but the output slot cannot take it.
        if (r_count == '0)
            w_state = IDLE;
        else if (r_count == LAST && bit_valid && w_blocked)
            w_state = STALL;
        else
            w_state = FILL;

        // Gated by rst_n so upstream is never drained while held in reset.
        w_take = rst_n && bit_valid && !abort && (w_state != STALL);

        if (abort) begin
            w_sreg_nxt  = '0;
            w_count_nxt = '0;
        end else if (w_take) begin
            if (r_count == LAST) begin
                w_load      = 1'b1;
                w_count_nxt = '0;
            end else begin
                w_sreg_nxt  = w_word_nxt[WIDTH-2:0];
                w_count_nxt = r_count + CNT_W'(1);
            end
        end

        drain = w_take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg     <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
        end else begin
            r_sreg  <= w_sreg_nxt;
            r_count <= w_count_nxt;
            if (w_fire)
                r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
        end
    end

    bp_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_word   (w_word_nxt),
        .i_accept (out_ready),
        .o_word   (w_out_word),
        .o_valid  (w_out_valid),
        .o_fire   (w_fire)
    );

    assign out_word  = w_out_word;
    assign out_valid = w_out_valid;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_bit_packer.sv
module tb_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_data = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        drain;
    logic        out_valid;
    logic [7:0]  out_word;
    logic [15:0] word_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        bv;
        logic        bd;
        logic        ab;
        logic        rdy;
        logic        exp_drain;
        logic        exp_ov;
        logic [7:0]  exp_ow;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bit_packer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .drain     (drain),
        .abort     (abort),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [7:0] ow, input logic [15:0] cnt);
        chk({tag, ".out_valid"}, out_valid, ov);
        chk({tag, ".out_word"},  out_word,  ow);
        chk({tag, ".word_cnt"},  word_cnt,  cnt);
    endtask

    task automatic drive(input logic bv, input logic bd, input logic ab, input logic rdy);
        bit_valid = bv;
        bit_data  = bd;
        abort     = ab;
        out_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic bv, input logic bd, input logic ab, input logic rdy,
                       input logic ed, input logic eov, input logic [7:0] eow, input logic [15:0] ecnt);
        vec_t v;
        v.bv = bv; v.bd = bd; v.ab = ab; v.rdy = rdy;
        v.exp_drain = ed; v.exp_ov = eov; v.exp_ow = eow; v.exp_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic send_bits(input string tag, input logic [7:0] w, input logic rdy);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[7-i], 1'b0, rdy);
            chk({tag, ".drain"}, drain, 1'b1);
            tick();
        end
    endtask

    initial begin
        logic [7:0] w;

        // Table: 0xA5 with ready, 0x96 back-to-back, 0x0F completing on
        // the very edge its predecessor is accepted, then one idle cycle.
        w = 8'hA5;
        for (int i = 0; i < 8; i++)
            add(1'b1, w[7-i], 1'b0, 1'b1, 1'b1, (i == 7), (i == 7) ? 8'hA5 : 8'h00, 16'd0);
        w = 8'h96;
        for (int i = 0; i < 8; i++)
            add(1'b1, w[7-i], 1'b0, 1'b1, 1'b1, (i == 7), (i == 7) ? 8'h96 : 8'hA5, 16'd1);
        w = 8'h0F;
        for (int i = 0; i < 8; i++)
            add(1'b1, w[7-i], 1'b0, (i == 7), 1'b1, 1'b1, (i == 7) ? 8'h0F : 8'h96,
                (i == 7) ? 16'd2 : 16'd1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, 16'd3);

        // Reset state, with upstream offering a bit during reset.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset.drain", drain, 1'b0);
        chk_out("reset", 1'b0, 8'h00, 16'd0);
        tick();
        tick();
        chk("reset_hold.drain", drain, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].bv, vecs[k].bd, vecs[k].ab, vecs[k].rdy);
            chk($sformatf("vec%0d.drain", k), drain, vecs[k].exp_drain);
            tick();
            chk_out($sformatf("vec%0d", k), vecs[k].exp_ov, vecs[k].exp_ow, vecs[k].exp_cnt);
        end

        // Stall: 0xFF held unaccepted, last bit of 0x00 blocked.
        send_bits("stall_ff", 8'hFF, 1'b0);
        chk_out("stall_ff", 1'b1, 8'hFF, 16'd3);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            chk("stall_fill.drain", drain, 1'b1);
            tick();
        end
        chk_out("stall_fill", 1'b1, 8'hFF, 16'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            chk("stall.drain", drain, 1'b0);
            tick();
            chk_out("stall", 1'b1, 8'hFF, 16'd3);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("stall_release.drain", drain, 1'b1);
        tick();
        chk_out("stall_release", 1'b1, 8'h00, 16'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("stall_done", 1'b0, 8'h00, 16'd5);

        // Abort after 3 bits, then a clean 0x3C.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort.drain", drain, 1'b0);
        tick();
        chk_out("abort", 1'b0, 8'h00, 16'd5);
        send_bits("abort_3c", 8'h3C, 1'b1);
        chk_out("abort_3c", 1'b1, 8'h3C, 16'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("abort_done", 1'b0, 8'h3C, 16'd6);

        // Asynchronous reset in mid-cycle after 5 bits, then 0x81.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midreset.drain", drain, 1'b0);
        chk_out("midreset", 1'b0, 8'h00, 16'd0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits("post_reset_81", 8'h81, 1'b1);
        chk_out("post_reset_81", 1'b1, 8'h81, 16'd0);

        // 0x5A with 1..3 cycle bit_valid gaps.
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[7-i], 1'b0, 1'b1);
            chk("gap_bit.drain", drain, 1'b1);
            tick();
            if (i < 7) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    drive(1'b0, 1'b1, 1'b0, 1'b1);
                    chk("gap_idle.drain", drain, 1'b0);
                    tick();
                end
            end
        end
        chk_out("gap_5a", 1'b1, 8'h5A, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter: WIDTH, default 8, bits per packed word (2..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: bit_valid  input  1  upstream holding-stage valid (its next-state valid output).
REQ-005 Port: bit_data  input  1  upstream holding-stage data bit (its next-state data output).
REQ-006 Port: drain  output  1  consume strobe returned to upstream; clears its valid.
REQ-007 Port: abort  input  1  synchronous discard of partial word.
REQ-008 Port: out_word  output  WIDTH  packed word, MSB = first bit received.
REQ-009 Port: out_valid  output  1  out_word holds an unconsumed word.
REQ-010 Port: out_ready  input  1  downstream accepts out_word this cycle.
REQ-011 Port: word_cnt  output  16  count of words accepted downstream; wraps at 65535->0.

Function
REQ-012 States: IDLE (count=0), FILL (0<count<WIDTH), STALL (count=WIDTH-1, bit_valid=1, slot blocked).
REQ-013 blocked = out_valid && !out_ready; take = bit_valid && !abort && !(count==WIDTH-1 && blocked).
REQ-014 drain = take, combinational, same cycle; drain never 1 when bit_valid=0.
REQ-015 On take with count<WIDTH-1: sreg <= {sreg[WIDTH-2:0], bit_data}; count <= count+1.
REQ-016 On take with count==WIDTH-1: out_word <= {sreg[WIDTH-2:0], bit_data}; out_valid <= 1; count <= 0.
REQ-017 Latency: final bit seen at edge N -> out_valid=1 after edge N; zero bubble between words.
REQ-018 out_valid && out_ready at edge with no new word completing -> out_valid <= 0, out_word held.
REQ-019 Accept and completion same edge -> out_valid stays 1, out_word replaced; no word lost or duplicated.
REQ-020 word_cnt increments by 1 on every edge where out_valid && out_ready.
REQ-021 STALL: drain=0, sreg/count held until out_ready=1; then take fires same cycle.
REQ-022 abort=1: count <= 0, sreg <= 0, drain=0; out_valid/out_word/word_cnt unaffected; state -> IDLE.
REQ-023 bit_valid=0 while in FILL: state held indefinitely, no timeout.
REQ-024 out_word and out_valid change only at edges; out_valid never drops without out_ready.

Reset
REQ-025 rst_n=0 asynchronously forces: state IDLE, count 0, sreg 0, out_word 0, out_valid 0, word_cnt 0.
REQ-026 drain=0 throughout reset; reset mid-word discards partial bits; first edge after release may take.

Structure
REQ-027 Package bit_packer_pkg holds: WIDTH default constant, state enum (IDLE, FILL, STALL), WORD_CNT_W=16.
REQ-028 Single sub-module bp_out_slot: one-entry out_word/out_valid register with load/accept inputs.
REQ-029 Next-state and drain logic in one purely combinational block; no latches inferred.

Verification
REQ-030 WIDTH=8, out_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> 8 drains, out_word=0xA5, out_valid one cycle, word_cnt=1.
REQ-031 out_ready=0, 16 bits of 0xFF then 0x00 -> out_word=0xFF held, 16th bit stalls (drain=0) until out_ready=1, then drain and out_word=0x00.
REQ-032 Back-to-back words, out_ready=1 -> out_valid continuously 1 across boundary, word_cnt increments every 8 cycles.
REQ-033 3 bits then abort=1 one cycle, then 8 bits of 0x3C -> out_word=0x3C, no stale bits.
REQ-034 rst_n=0 mid-edge-cycle after 5 bits -> outputs zero immediately; next 8 bits 0x81 -> out_word=0x81.
REQ-035 bit_valid gaps of 1-3 cycles between bits of 0x5A -> out_word=0x5A, drain pulses only with bit_valid=1.
